// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle instruction sequencer for the accumulator datapath.
// Steps each instruction through fetch/decode/memory/execute and drives datapath strobes.
module proc_ctrl_fsm #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned ALUW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_i,
  input  logic [7:0]      instr_i,
  input  logic            mem_ready_i,
  input  logic            alu_zero_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            addr_sel_o,
  output logic            ir_load_o,
  output logic            pc_inc_o,
  output logic            pc_load_o,
  output logic            acc_load_o,
  output logic [1:0]      acc_src_o,
  output logic [ALUW-1:0] alu_op_o,
  output logic            halted_o,
  output logic            illegal_o,
  output logic [2:0]      state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEMRD  = 3'd3;
  localparam logic [2:0] S_MEMWR  = 3'd4;
  localparam logic [2:0] S_EXEC   = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_STA = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4);
  localparam logic [OPW-1:0] OP_ADD = OPW'(5);
  localparam logic [OPW-1:0] OP_SUB = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP = OPW'(7);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(8);
  localparam logic [OPW-1:0] OP_LDI = OPW'(9);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  localparam logic [ALUW-1:0] ALU_AND  = ALUW'(0);
  localparam logic [ALUW-1:0] ALU_OR   = ALUW'(1);
  localparam logic [ALUW-1:0] ALU_ADD  = ALUW'(2);
  localparam logic [ALUW-1:0] ALU_SUB  = ALUW'(3);
  localparam logic [ALUW-1:0] ALU_PASS = ALUW'(4);

  logic [2:0]     state;
  logic [2:0]     state_nxt;
  logic [2:0]     boundary_nxt;
  logic [OPW-1:0] op_q;
  logic           run_q;
  logic           unused_operand_bits;

  // Operand nibble is consumed by the datapath, not by the sequencer.
  assign unused_operand_bits = ^instr_i[7-OPW:0];

  // State, private opcode copy and run_i history for HALT edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= '0;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= run_i;
      if (state == S_FETCH && mem_ready_i) begin
        op_q <= instr_i[7 -: OPW];
      end
    end
  end

  // Next state and combinational datapath controls.
  always_comb begin
    state_nxt    = state;
    boundary_nxt = run_i ? S_FETCH : S_IDLE;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    addr_sel_o   = 1'b0;
    ir_load_o    = 1'b0;
    pc_inc_o     = 1'b0;
    pc_load_o    = 1'b0;
    acc_load_o   = 1'b0;
    acc_src_o    = 2'd0;
    alu_op_o     = ALU_AND;
    halted_o     = 1'b0;
    illegal_o    = 1'b0;

    case (state)
      S_IDLE: begin
        if (run_i) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_load_o = 1'b1;
          pc_inc_o  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op_q)
          OP_HLT:                                 state_nxt = S_HALT;
          OP_NOP:                                 state_nxt = boundary_nxt;
          OP_LDA, OP_AND, OP_OR, OP_ADD, OP_SUB:  state_nxt = S_MEMRD;
          OP_STA:                                 state_nxt = S_MEMWR;
          OP_JMP, OP_JZ, OP_LDI:                  state_nxt = S_EXEC;
          default: begin
            illegal_o = 1'b1;
            state_nxt = boundary_nxt;
          end
        endcase
      end
      S_MEMRD: begin
        mem_req_o  = 1'b1;
        addr_sel_o = 1'b1;
        case (op_q)
          OP_LDA:  acc_src_o = 2'd1;
          OP_OR:   alu_op_o  = ALU_OR;
          OP_ADD:  alu_op_o  = ALU_ADD;
          OP_SUB:  alu_op_o  = ALU_SUB;
          default: alu_op_o  = ALU_AND;
        endcase
        if (mem_ready_i) begin
          acc_load_o = 1'b1;
          state_nxt  = boundary_nxt;
        end
      end
      S_MEMWR: begin
        // Accumulator reaches the write bus through the ALU pass path.
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        addr_sel_o = 1'b1;
        alu_op_o   = ALU_PASS;
        if (mem_ready_i) state_nxt = boundary_nxt;
      end
      S_EXEC: begin
        case (op_q)
          OP_JMP: pc_load_o = 1'b1;
          OP_JZ:  pc_load_o = alu_zero_i;
          OP_LDI: begin
            acc_load_o = 1'b1;
            acc_src_o  = 2'd2;
          end
          default: ;
        endcase
        state_nxt = boundary_nxt;
      end
      S_HALT: begin
        halted_o = 1'b1;
        if (run_i && !run_q) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign state_o = state;

endmodule
